// File: rtl/image_ram_scanout.sv
// ---------------------------------------------------------------------------
// image_ram_scanout
//
// Prefetches one frame of 8 bpp pixels (four pixels per 32-bit word) from an
// image RAM and presents the pixels one at a time to a VGA timing block.
// A small FIFO hides the RAM read latency so the pixel stream keeps up with
// active video.
//
// Parameters
//   BASE_ADDR    word address of pixel 0 of the frame
//   FRAME_WORDS  words per frame (1..256000)
//   FIFO_DEPTH   prefetch depth in words (power of 2, 4..32)
//
// Ports
//   clk             single clock
//   reset           asynchronous, active-high reset
//   frame_start     one-cycle pulse at vertical blank, restarts the fetch
//   pix_ready       VGA side consumes one pixel this cycle
//   pix_data        current pixel, RGB332
//   pix_valid       pix_data holds a valid pixel
//   underflow       sticky: pixel demanded while none was available
//   ram_address     word address to the RAM read port
//   ram_chipselect  read strobe to the RAM read port
//   ram_write       tied 0
//   ram_clken       tied 1
//   ram_readdata    RAM read data, valid the cycle after the address cycle
// ---------------------------------------------------------------------------
module image_ram_scanout #(
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 76800,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        underflow,
  output logic [17:0] ram_address,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic        ram_clken,
  input  logic [31:0] ram_readdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [17:0] BASE      = 18'(BASE_ADDR);
  localparam logic [17:0] LAST_WORD = 18'(FRAME_WORDS - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [17:0]   issued;
  logic          inflight;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic [31:0]   unpack_word;
  logic [1:0]    pix_idx;
  logic          unpack_full;

  logic [CW:0]   words_held;
  logic          issue;
  logic          push;
  logic          pop;
  logic          consume;
  logic          last_pixel;
  logic          frame_done;

  // Words the block is responsible for: stored, on their way from the RAM,
  // or being unpacked. Counting the unpack word keeps the total bounded by
  // FIFO_DEPTH, so a fresh frame fetches exactly FIFO_DEPTH words ahead.
  assign words_held = (CW+1)'(fifo_count) + (CW+1)'(inflight) + (CW+1)'(unpack_full);

  // No issue in the frame_start cycle: that read would be discarded anyway.
  assign issue      = (state == FETCH) && !frame_start &&
                      (words_held < (CW+1)'(FIFO_DEPTH));
  assign push       = inflight;
  assign consume    = pix_ready && unpack_full;
  assign last_pixel = consume && (pix_idx == 2'd3);
  assign pop        = (fifo_count != '0) && (!unpack_full || last_pixel);

  // Leave DRAIN on the same edge that frees the last pixel, so a continuously
  // ready consumer never sees an empty DRAIN cycle.
  assign frame_done = (fifo_count == '0) && !inflight && (!unpack_full || last_pixel);

  assign ram_chipselect = issue;
  assign ram_address    = BASE + issued;  // 18-bit wrap is the intended modulo
  assign ram_write      = 1'b0;
  assign ram_clken      = 1'b1;

  assign pix_valid = unpack_full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pix_data = 8'd0;
    if (unpack_full) begin
      case (pix_idx)
        2'd0:    pix_data = unpack_word[7:0];
        2'd1:    pix_data = unpack_word[15:8];
        2'd2:    pix_data = unpack_word[23:16];
        default: pix_data = unpack_word[31:24];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (issue && (issued == LAST_WORD)) state_nxt = DRAIN;
      DRAIN:   if (frame_done) state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    if (frame_start) state_nxt = FETCH;
  end

  // Frame control, read issue and the sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      issued    <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (frame_start) begin
        issued   <= '0;
        inflight <= 1'b0;
      end else begin
        if (issue) issued <= issued + 18'd1;
        inflight <= issue;
      end
      if (pix_ready && !unpack_full && (state != IDLE)) underflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; frame_start flushes, dropping any push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone says which entries
  // are meaningful, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push && !frame_start) fifo_mem[wr_ptr] <= ram_readdata;
  end

  // Unpack register: refills from the FIFO in the same cycle its last pixel
  // is consumed, so there is no gap between words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unpack_word <= '0;
      pix_idx     <= 2'd0;
      unpack_full <= 1'b0;
    end else if (frame_start) begin
      unpack_word <= '0;
      pix_idx     <= 2'd0;
      unpack_full <= 1'b0;
    end else if (pop) begin
      unpack_word <= fifo_mem[rd_ptr];
      pix_idx     <= 2'd0;
      unpack_full <= 1'b1;
    end else if (consume) begin
      if (last_pixel) begin
        pix_idx     <= 2'd0;
        unpack_full <= 1'b0;
      end else begin
        pix_idx <= pix_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_ram_scanout.sv
// ---------------------------------------------------------------------------
// tb_image_ram_scanout
//
// Scoreboard bench for image_ram_scanout. Each frame_start pushes the full
// expected pixel stream of the frame into a queue; a negedge monitor pops and
// compares on every pix_valid & pix_ready, checks every read address, and
// bounds the words held (reads issued minus words fully consumed). The frame
// is placed two words below the top of the 18-bit address space so the
// address wraps early in every frame.
// ---------------------------------------------------------------------------
module tb_image_ram_scanout;

  localparam int BASE  = 262142;
  localparam int FW    = 300;
  localparam int DEPTH = 8;
  localparam int ASPACE = 262144;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        underflow;
  logic [17:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic        ram_clken;
  logic [31:0] ram_readdata;

  image_ram_scanout #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .underflow     (underflow),
    .ram_address   (ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_write     (ram_write),
    .ram_clken     (ram_clken),
    .ram_readdata  (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int reads = 0;
  int consumed = 0;
  int first_rd_cyc = 0;
  int last_rd_cyc  = 0;
  logic [17:0] last_addr = '0;
  logic [7:0]  exp_q[$];
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Image RAM content: word n holds bytes 4n..4n+3 (mod 256), low byte first.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    logic [7:0] b;
    b = {a[5:0], 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Pixel p of the frame: byte p%4 of word (BASE + p/4) mod 2^18.
  function automatic logic [7:0] exp_pixel(input int p);
    int a;
    a = (BASE + p / 4) % ASPACE;
    return 8'((a * 4 + p % 4) % 256);
  endfunction

  // One-cycle-latency RAM; junk when not selected exposes mistimed captures.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_chipselect) ram_readdata <= mem_word(ram_address);
    else                ram_readdata <= $urandom;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_chipselect) begin
        check("rd_within_frame", 32'(reads < FW), 1);
        check("rd_addr", 32'(ram_address), 32'((BASE + reads) % ASPACE));
        check("words_held", 32'((reads + 1 - consumed / 4) <= DEPTH), 1);
        if (reads == 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        last_addr   = ram_address;
        reads++;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        end
        consumed++;
      end
    end
  end

  // Pulse frame_start for one cycle with pix_ready low and load the
  // expected stream for the new frame.
  task automatic start_frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    pix_ready   = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 4 * FW; p++) exp_q.push_back(exp_pixel(p));
    reads    = 0;
    consumed = 0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_until_empty(input int max_cycles, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk); #1;
      if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset       = 1'b1;
    frame_start = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_chipselect", 32'(ram_chipselect), 0);
    check("rst_address", 32'(ram_address), 32'(BASE));
    check("ram_write", 32'(ram_write), 0);
    check("ram_clken", 32'(ram_clken), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    check("idle_no_reads", 32'(reads), 0);

    // Prefetch with no consumer: exactly DEPTH back-to-back reads.
    start_frame();
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("prefetch_reads", 32'(reads), DEPTH);
    check("prefetch_back_to_back", 32'(last_rd_cyc - first_rd_cyc), DEPTH - 1);
    check("prefetch_cs_low", 32'(ram_chipselect), 0);
    check("prefetch_valid", 32'(pix_valid), 1);
    check("prefetch_pixel0", 32'(pix_data), 32'(exp_pixel(0)));

    // Full frame, consumer ready continuously once the first pixel shows.
    start_frame();
    n = 0;
    while (!pix_valid && n < 20) begin @(negedge clk); n++; end
    check("first_valid_timeout", 32'(pix_valid), 1);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    run_until_empty(4 * FW + 100, "cont_frame_done");
    @(negedge clk);
    check("cont_reads", 32'(reads), FW);
    check("cont_last_addr", 32'(last_addr), 32'((BASE + FW - 1) % ASPACE));
    check("cont_underflow", 32'(underflow), 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_ready_ignored", 32'(underflow), 0);
    check("idle_valid_low", 32'(pix_valid), 0);
    pix_ready = 1'b0;

    // Ready the cycle after frame_start: underflow, but pixel 0 comes first.
    start_frame();
    pix_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("underflow_set", 32'(underflow), 1);
    check("some_pixels_out", 32'(consumed > 0), 1);

    // Restart while a read is in flight; its data must not be delivered.
    n = 0;
    @(negedge clk);
    while (!ram_chipselect && n < 100) begin @(negedge clk); n++; end
    check("inflight_seen", 32'(ram_chipselect), 1);
    start_frame();
    @(negedge clk);
    check("underflow_sticky", 32'(underflow), 1);

    // Random consumer over the rest of the frame.
    rand_ready = 1'b1;
    run_until_empty(20 * FW + 200, "rand_frame_done");
    rand_ready = 1'b0;
    pix_ready  = 1'b0;
    @(negedge clk);
    check("rand_reads", 32'(reads), FW);

    // Reset mid-frame aborts and the block waits for frame_start.
    start_frame();
    rand_ready = 1'b1;
    repeat (50) begin @(posedge clk); #1; pix_ready = 1'($urandom_range(0, 1)); end
    rand_ready = 1'b0;
    pix_ready  = 1'b0;
    reset      = 1'b1;
    #1;
    check("midrst_valid", 32'(pix_valid), 0);
    check("midrst_data", 32'(pix_data), 0);
    check("midrst_underflow", 32'(underflow), 0);
    check("midrst_cs", 32'(ram_chipselect), 0);
    check("midrst_addr", 32'(ram_address), 32'(BASE));
    exp_q.delete();
    reads    = 0;
    consumed = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_reads", 32'(reads), 0);
    check("post_rst_valid", 32'(pix_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
